// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types and defaults for the enemy hit manager
package enemy_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } scan_state_t;

    localparam int COORD_W_DEF = 10;
    localparam int BOX_W_DEF   = 32;
    localparam int BOX_H_DEF   = 32;
    localparam int KILL_CNT_W  = 16;

endpackage

// File: rtl/box_hit_vec.sv
// rtl/box_hit_vec.sv - one hitbox tested against a vector of points (combinational)
module box_hit_vec
    import enemy_pkg::*;
#(
    parameter int BULLET_COUNT = 8,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int BOX_W        = BOX_W_DEF,
    parameter int BOX_H        = BOX_H_DEF
) (
    input  logic [COORD_W-1:0]              box_x,
    input  logic [COORD_W-1:0]              box_y,
    input  logic [COORD_W*BULLET_COUNT-1:0] pt_x_flat,
    input  logic [COORD_W*BULLET_COUNT-1:0] pt_y_flat,
    output logic [BULLET_COUNT-1:0]         overlap
);

    // One extra bit keeps boxes near the right/bottom edge from wrapping.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, box_x} + (COORD_W+1)'(BOX_W);
    assign y_end = {1'b0, box_y} + (COORD_W+1)'(BOX_H);

    always_comb begin
        overlap = '0;
        for (int b = 0; b < BULLET_COUNT; b++) begin
            overlap[b] = (pt_x_flat[b*COORD_W +: COORD_W] >= box_x)
                      && ({1'b0, pt_x_flat[b*COORD_W +: COORD_W]} < x_end)
                      && (pt_y_flat[b*COORD_W +: COORD_W] >= box_y)
                      && ({1'b0, pt_y_flat[b*COORD_W +: COORD_W]} < y_end);
        end
    end

endmodule

// File: rtl/enemy_hit_manager.sv
// rtl/enemy_hit_manager.sv - per-frame bullet/enemy hit scan with per-enemy HP
// Optional KILL_COUNTER_EN: implements the saturating kill_count register.
module enemy_hit_manager
    import enemy_pkg::*;
#(
    parameter int ENEMY_COUNT  = 23,
    parameter int BULLET_COUNT = 8,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int BOX_W        = BOX_W_DEF,
    parameter int BOX_H        = BOX_H_DEF,
    parameter int HP_W         = 2,
    parameter int GROUP_COUNT  = 3,
    parameter int GID_W        = 2
) (
    input  logic                            clk25,
    input  logic                            rst_n,
    input  logic                            frame_start,
    input  logic [COORD_W*BULLET_COUNT-1:0] bullet_x_flat,
    input  logic [COORD_W*BULLET_COUNT-1:0] bullet_y_flat,
    input  logic [BULLET_COUNT-1:0]         bullet_active_flat,
    input  logic [COORD_W*ENEMY_COUNT-1:0]  enemy_x_flat,
    input  logic [COORD_W*ENEMY_COUNT-1:0]  enemy_y_flat,
    input  logic [GID_W*ENEMY_COUNT-1:0]    enemy_gid_flat,
    input  logic [GROUP_COUNT-1:0]          group_reset,
    input  logic [HP_W*GROUP_COUNT-1:0]     group_hp_flat,
    output logic [BULLET_COUNT-1:0]         bullet_hit,
    output logic [ENEMY_COUNT-1:0]          enemy_alive,
    output logic                            kill_pulse,
    output logic [KILL_CNT_W-1:0]           kill_count,
    output logic                            scan_busy,
    output logic                            scan_done
);

    localparam int IDX_W = $clog2(ENEMY_COUNT);

    scan_state_t                     state;
    logic [IDX_W-1:0]                idx;
    logic [COORD_W*BULLET_COUNT-1:0] snap_x;
    logic [COORD_W*BULLET_COUNT-1:0] snap_y;
    logic [BULLET_COUNT-1:0]         snap_act;
    logic [BULLET_COUNT-1:0]         consumed;
    logic [HP_W-1:0]                 hp      [ENEMY_COUNT];
    logic [HP_W-1:0]                 hp_next [ENEMY_COUNT];
    logic                            grp_load [ENEMY_COUNT];
    logic [COORD_W-1:0]              cur_x;
    logic [COORD_W-1:0]              cur_y;
    logic [BULLET_COUNT-1:0]         overlap;
    logic [BULLET_COUNT-1:0]         new_hits;
    logic                            scan_hit;
    logic                            kill_now;

    assign cur_x = enemy_x_flat[idx*COORD_W +: COORD_W];
    assign cur_y = enemy_y_flat[idx*COORD_W +: COORD_W];

    box_hit_vec #(
        .BULLET_COUNT(BULLET_COUNT),
        .COORD_W     (COORD_W),
        .BOX_W       (BOX_W),
        .BOX_H       (BOX_H)
    ) u_box_hit_vec (
        .box_x    (cur_x),
        .box_y    (cur_y),
        .pt_x_flat(snap_x),
        .pt_y_flat(snap_y),
        .overlap  (overlap)
    );

    assign new_hits = (state == S_SCAN && hp[idx] != '0) ? (overlap & snap_act & ~consumed) : '0;
    assign scan_hit = |new_hits;

    always_comb begin
        for (int i = 0; i < ENEMY_COUNT; i++) begin
            grp_load[i] = 1'b0;
            for (int g = 0; g < GROUP_COUNT; g++) begin
                if (group_reset[g] && enemy_gid_flat[i*GID_W +: GID_W] == GID_W'(g))
                    grp_load[i] = 1'b1;
            end
        end
    end

    // A group reload overrides a same-cycle decrement and suppresses its kill.
    always_comb begin
        kill_now = 1'b0;
        for (int i = 0; i < ENEMY_COUNT; i++) begin
            hp_next[i] = hp[i];
            if (scan_hit && idx == IDX_W'(i)) begin
                hp_next[i] = hp[i] - HP_W'(1);
                kill_now   = (hp[i] == HP_W'(1));
            end
            if (grp_load[i]) begin
                hp_next[i] = group_hp_flat[int'(enemy_gid_flat[i*GID_W +: GID_W])*HP_W +: HP_W];
                if (idx == IDX_W'(i))
                    kill_now = 1'b0;
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            snap_act    <= '0;
            consumed    <= '0;
            bullet_hit  <= '0;
            enemy_alive <= '0;
            kill_pulse  <= 1'b0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
            for (int i = 0; i < ENEMY_COUNT; i++)
                hp[i] <= '0;
        end else begin
            for (int i = 0; i < ENEMY_COUNT; i++) begin
                hp[i]          <= hp_next[i];
                enemy_alive[i] <= (hp_next[i] != '0);
            end
            kill_pulse <= kill_now;
            bullet_hit <= '0;
            scan_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        snap_x    <= bullet_x_flat;
                        snap_y    <= bullet_y_flat;
                        snap_act  <= bullet_active_flat;
                        consumed  <= '0;
                        idx       <= '0;
                        scan_busy <= 1'b1;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    consumed <= consumed | new_hits;
                    if (idx == IDX_W'(ENEMY_COUNT-1)) begin
                        bullet_hit <= consumed | new_hits;
                        scan_done  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    scan_busy <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KILL_COUNTER_EN
    logic [KILL_CNT_W-1:0] kill_cnt_q;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n)
            kill_cnt_q <= '0;
        else if (kill_now && kill_cnt_q != '1)
            kill_cnt_q <= kill_cnt_q + KILL_CNT_W'(1);
    end

    assign kill_count = kill_cnt_q;
`else
    assign kill_count = '0;
`endif

endmodule

// File: tb/tb_enemy_hit_manager.sv
// tb/tb_enemy_hit_manager.sv - self-checking bench for enemy_hit_manager
module tb_enemy_hit_manager;

    localparam int NE = 23;
    localparam int NB = 8;
    localparam int CW = 10;

    logic           clk25 = 1'b0;
    logic           rst_n;
    logic           frame_start;
    logic [CW*NB-1:0] bullet_x_flat, bullet_y_flat;
    logic [NB-1:0]  bullet_active_flat;
    logic [CW*NE-1:0] enemy_x_flat, enemy_y_flat;
    logic [2*NE-1:0] enemy_gid_flat;
    logic [2:0]     group_reset;
    logic [5:0]     group_hp_flat;
    logic [NB-1:0]  bullet_hit;
    logic [NE-1:0]  enemy_alive;
    logic           kill_pulse;
    logic [15:0]    kill_count;
    logic           scan_busy;
    logic           scan_done;

    logic [CW-1:0] bx [NB];
    logic [CW-1:0] by [NB];
    logic [NB-1:0] ba;
    logic [CW-1:0] ex [NE];
    logic [CW-1:0] ey [NE];
    logic [1:0]    gid_a [NE];
    logic [1:0]    ghp [3];

    int n_checks = 0;
    int n_fail   = 0;
    int kp_seen  = 0;
    int done_seen = 0;

    enemy_hit_manager dut (
        .clk25(clk25), .rst_n(rst_n), .frame_start(frame_start),
        .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
        .bullet_active_flat(bullet_active_flat),
        .enemy_x_flat(enemy_x_flat), .enemy_y_flat(enemy_y_flat),
        .enemy_gid_flat(enemy_gid_flat), .group_reset(group_reset),
        .group_hp_flat(group_hp_flat), .bullet_hit(bullet_hit),
        .enemy_alive(enemy_alive), .kill_pulse(kill_pulse),
        .kill_count(kill_count), .scan_busy(scan_busy), .scan_done(scan_done)
    );

    always #20 clk25 = ~clk25;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            bullet_x_flat[i*CW +: CW] = bx[i];
            bullet_y_flat[i*CW +: CW] = by[i];
        end
        for (int i = 0; i < NE; i++) begin
            enemy_x_flat[i*CW +: CW] = ex[i];
            enemy_y_flat[i*CW +: CW] = ey[i];
            enemy_gid_flat[i*2 +: 2] = gid_a[i];
        end
        for (int g = 0; g < 3; g++)
            group_hp_flat[g*2 +: 2] = ghp[g];
        bullet_active_flat = ba;
    end

    // Model: frame age counts cycles since an accepted frame_start;
    // age k in 1..23 means enemy k-1 is examined, age 24 is the result cycle.
    int          m_hp [NE];
    int          nhp [NE];
    int          m_age = 0;
    int          m_kc = 0;
    logic        m_kp = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [NB-1:0] m_bhit = '0;
    logic [NB-1:0] m_cons = '0;
    logic [NB-1:0] hits;
    int          s_x [NB];
    int          s_y [NB];
    logic [NB-1:0] s_act = '0;

    function automatic bit inbox(int px, int py, int qx, int qy);
        return px >= qx && px < qx + 32 && py >= qy && py < qy + 32;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) m_hp[i] = 0;
        m_age = 0; m_kc = 0; m_kp = 0; m_busy = 0; m_done = 0;
        m_bhit = '0; m_cons = '0;
    endtask

    initial model_clear();
    always @(negedge rst_n) model_clear();

    always @(posedge clk25) begin
        if (rst_n === 1'b1) begin
            nhp = m_hp;
            m_kp = 1'b0;
            if (m_age >= 1 && m_age <= NE) begin
                hits = '0;
                if (m_hp[m_age-1] > 0)
                    for (int b = 0; b < NB; b++)
                        if (s_act[b] && !m_cons[b] &&
                            inbox(s_x[b], s_y[b], int'(ex[m_age-1]), int'(ey[m_age-1])))
                            hits[b] = 1'b1;
                if (hits != '0) begin
                    nhp[m_age-1] = m_hp[m_age-1] - 1;
                    m_kp = (nhp[m_age-1] == 0);
                    m_cons = m_cons | hits;
                end
            end
            for (int e = 0; e < NE; e++) begin
                if (int'(gid_a[e]) < 3 && group_reset[gid_a[e]]) begin
                    nhp[e] = int'(ghp[gid_a[e]]);
                    if (m_age >= 1 && m_age <= NE && e == m_age - 1) m_kp = 1'b0;
                end
            end
`ifdef KILL_COUNTER_EN
            if (m_kp && m_kc < 65535) m_kc++;
`endif
            m_hp = nhp;
            if (m_age == 0) begin
                if (frame_start) begin
                    for (int b = 0; b < NB; b++) begin
                        s_x[b] = int'(bx[b]);
                        s_y[b] = int'(by[b]);
                    end
                    s_act = ba;
                    m_cons = '0;
                    m_age = 1;
                end
            end else if (m_age == NE + 1) begin
                m_age = 0;
            end else begin
                m_age++;
            end
            m_busy = (m_age != 0);
            m_done = (m_age == NE + 1);
            m_bhit = m_done ? m_cons : '0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk25) begin
        logic [NE-1:0] exp_alive;
        for (int i = 0; i < NE; i++) exp_alive[i] = (m_hp[i] != 0);
        chk("cyc_busy", scan_busy, m_busy);
        chk("cyc_done", scan_done, m_done);
        chk("cyc_bullet_hit", bullet_hit, m_bhit);
        chk("cyc_kill_pulse", kill_pulse, m_kp);
        chk("cyc_kill_count", kill_count, m_kc);
        chk("cyc_alive", enemy_alive, exp_alive);
        if (rst_n === 1'b1 && kill_pulse) kp_seen++;
        if (rst_n === 1'b1 && scan_done) done_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic greset(input int g, input logic [1:0] v);
        ghp[g] = v;
        group_reset = 3'b001 << g;
        tick(1);
        group_reset = '0;
    endtask

    task automatic run_frame(output int lat);
        frame_start = 1'b1;
        tick(1);
        lat = 1;
        frame_start = 1'b0;
        while (!scan_done && lat < 60) begin
            tick(1);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int d0;
        rst_n = 1'b0;
        frame_start = 1'b0;
        group_reset = '0;
        ba = '0;
        for (int i = 0; i < NB; i++) begin bx[i] = '0; by[i] = '0; end
        for (int i = 0; i < NE; i++) begin
            ex[i] = CW'(i * 40);
            ey[i] = CW'(900);
            gid_a[i] = (i == NE - 1) ? 2'd3 : 2'(i % 3);
        end
        for (int g = 0; g < 3; g++) ghp[g] = 2'd0;
        tick(2);
        chk("reset_alive", enemy_alive, 0);
        chk("reset_busy", scan_busy, 0);
        rst_n = 1'b1;
        tick(1);

        // single bullet, two frames to kill a 2-HP enemy
        greset(0, 2'd2);
        ex[0] = 10'd100; ey[0] = 10'd100;
        bx[3] = 10'd110; by[3] = 10'd110; ba = 8'b0000_1000;
        run_frame(lat);
        chk("t1_latency", lat, NE + 1);
        chk("t1_bullet_hit", bullet_hit, 8'b0000_1000);
        tick(2);
        chk("t1_model_hp0", m_hp[0], 1);
        chk("t1_alive0", enemy_alive[0], 1);
        chk("t1_no_kill", kp_seen, 0);
        run_frame(lat);
        tick(2);
        chk("t1_kill_seen", kp_seen, 1);
        chk("t1_alive0_dead", enemy_alive[0], 0);
`ifdef KILL_COUNTER_EN
        chk("t1_kill_count", kill_count, 1);
`else
        chk("t1_kill_count", kill_count, 0);
`endif

        // two bullets on one enemy cost one HP
        greset(2, 2'd2);
        ex[5] = 10'd300; ey[5] = 10'd300;
        bx[0] = 10'd305; by[0] = 10'd305;
        bx[1] = 10'd330; by[1] = 10'd331;
        ba = 8'b0000_0011;
        run_frame(lat);
        chk("t2_bullet_hit", bullet_hit, 8'b0000_0011);
        tick(2);
        chk("t2_model_hp5", m_hp[5], 1);

        // overlapping enemies: lower index takes the bullet
        greset(1, 2'd3);
        ex[2] = 10'd500; ey[2] = 10'd500;
        ex[4] = 10'd500; ey[4] = 10'd500;
        bx[0] = 10'd510; by[0] = 10'd510; ba = 8'b0000_0001;
        run_frame(lat);
        chk("t3_bullet_hit", bullet_hit, 8'b0000_0001);
        tick(2);
        chk("t3_model_hp2", m_hp[2], 1);
        chk("t3_model_hp4", m_hp[4], 3);

        // right/bottom edges near the top of the coordinate range
        ex[7] = 10'd1000; ey[7] = 10'd600;
        bx[0] = 10'd1023; by[0] = 10'd631;
        bx[1] = 10'd1010; by[1] = 10'd632;
        bx[2] = 10'd999;  by[2] = 10'd610;
        bx[3] = 10'd1000; by[3] = 10'd600;
        ba = 8'b0000_1111;
        run_frame(lat);
        chk("t4_bullet_hit", bullet_hit, 8'b0000_1001);
        tick(2);
        chk("t4_model_hp7", m_hp[7], 2);

        // group reload during enemy 7's scan cycle, plus ignored frame_start
        d0 = done_seen;
        frame_start = 1'b1; tick(1); lat = 1; frame_start = 1'b0;
        tick(4); lat += 4;
        frame_start = 1'b1; tick(1); lat++; frame_start = 1'b0;
        tick(2); lat += 2;
        group_reset = 3'b010; ghp[1] = 2'd3; tick(1); lat++; group_reset = '0;
        while (!scan_done && lat < 60) begin tick(1); lat++; end
        chk("t5_latency", lat, NE + 1);
        chk("t5_bullet_hit", bullet_hit, 8'b0000_1001);
        tick(30);
        chk("t5_single_done", done_seen - d0, 1);
        chk("t5_model_hp7", m_hp[7], 3);
        chk("t5_alive7", enemy_alive[7], 1);

        // reset mid-scan aborts, next frame scans normally
        d0 = done_seen;
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
        tick(9);
        rst_n = 1'b0;
        tick(2);
        chk("t6_rst_alive", enemy_alive, 0);
        chk("t6_rst_busy", scan_busy, 0);
        rst_n = 1'b1;
        tick(30);
        chk("t6_no_done", done_seen - d0, 0);
        greset(0, 2'd1);
        bx[3] = 10'd110; by[3] = 10'd110; ba = 8'b0000_1000;
        d0 = kp_seen;
        run_frame(lat);
        chk("t6_latency", lat, NE + 1);
        chk("t6_bullet_hit", bullet_hit, 8'b0000_1000);
        tick(2);
        chk("t6_kill", kp_seen - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
